// File: rtl/sync_down_counter.sv
// sync_down_counter: loadable modulo down counter with one-shot or auto-reload modes.
//
// Counts from a reload value (rld) down to 0. On the expiry edge (Q == 0 while
// enabled in RUN) it either wraps to rld (auto_reload=1) or stops in DONE
// (auto_reload=0). Each expiry raises tc for exactly one cycle.
//
// Ports:
//   clk         - clock, rising edge active
//   reset       - asynchronous active-low reset
//   load        - capture load_val into both rld and Q (highest priority)
//   load_val    - value captured on load
//   start       - begin counting from rld (honoured in IDLE/DONE only)
//   en          - count enable; while low in RUN everything holds
//   auto_reload - sampled on the expiry edge: 1 = wrap, 0 = stop in DONE
//   Q           - current count (registered)
//   tc          - terminal-count pulse (registered, one cycle per expiry)
//   busy        - high while in RUN
//   done        - high while in DONE
module sync_down_counter #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rld_q, rld_d;
  logic             tc_q, tc_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rld_q   <= '1;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rld_q   <= rld_d;
      tc_q    <= tc_d;
    end
  end

  // Priority: load > start > count. tc defaults low so it can only ever be a
  // single-cycle pulse following an expiry edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rld_d   = rld_q;
    tc_d    = 1'b0;

    if (load) begin
      // Load restarts the count even in RUN at Q == 0, so no expiry is taken.
      rld_d = load_val;
      cnt_d = load_val;
      if (start && (state_q != StRun)) begin
        state_d = StRun;
      end
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            cnt_d   = rld_q;
            state_d = StRun;
          end
        end
        StRun: begin
          if (en) begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - WIDTH'(1);
            end else begin
              tc_d = 1'b1;
              if (auto_reload) begin
                cnt_d = rld_q;
              end else begin
                state_d = StDone;
              end
            end
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  assign Q    = cnt_q;
  assign tc   = tc_q;
  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);

endmodule

// File: doc/sync_down_counter.md
Name: sync_down_counter

Overview:
Synchronous, loadable, modulo down counter. Counts from a programmable reload value down to 0, then either wraps back to the reload value or stops.
- Issues a one-cycle terminal-count pulse at each expiry.
- Complements the team's up counters: the down-direction timer/divider used by the counter blocks of the same assignment set.

Parameters:
WIDTH, 3, counter and reload-value width in bits.

Ports:
clk  input  1  single clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
load  input  1  load reload register and counter from load_val.
load_val  input  WIDTH  value captured on load.
start  input  1  begin counting from the reload register (accepted in IDLE/DONE only).
en  input  1  count enable; while 0 in RUN, everything holds.
auto_reload  input  1  1 = wrap to reload value at 0; 0 = stop at 0 (one-shot).
Q  output  WIDTH  current count (registered).
tc  output  1  terminal-count pulse, exactly one cycle wide (registered).
busy  output  1  1 while in RUN.
done  output  1  1 while in DONE (one-shot expired).

Behaviour:
- Reset (reset=0, asynchronous, no clock needed):
  - Q=0, tc=0, busy=0, done=0, state=IDLE.
  - Internal reload register rld = all ones (7 for WIDTH=3).
  - Outputs stay at these values for as long as reset is held.
  - Release is sampled at the next rising clk edge.
- States: IDLE, RUN, DONE. busy = (state==RUN), done = (state==DONE), both decoded from registered state.
- Priority per edge: load > start > count.
- load=1 (any state):
  - rld <= load_val and Q <= load_val.
  - If also start=1 in IDLE/DONE, go to RUN; otherwise state is unchanged.
  - In RUN, load restarts the count from load_val with no tc that cycle, even if Q was 0.
- IDLE:
  - Q holds.
  - start=1 (no load): Q <= rld, go to RUN; first decrement happens on the following enabled edge.
- RUN, en=0: Q, state and tc all hold/inactive (tc=0).
- RUN, en=1, Q!=0: Q <= Q-1. Modulo arithmetic is never needed because 0 is handled separately.
- RUN, en=1, Q==0: tc <= 1 for the next cycle only.
  - auto_reload=1: Q <= rld, stay in RUN. Period = rld+1 enabled cycles.
  - auto_reload=0: Q stays 0, go to DONE.
- rld==0 with auto_reload=1: tc=1 on every enabled cycle; Q stays 0.
- DONE:
  - Q holds 0; done=1.
  - start=1: Q <= rld, go to RUN.
  - load behaves as above.
- start while in RUN is ignored.
- tc is 0 in every cycle not immediately following an expiry edge. It is never high two cycles in a row unless rld==0.
- auto_reload is sampled only on the expiry edge and may change freely otherwise.
- Reset asserted mid-count: immediate return to reset values, including rld = all ones. A previously loaded value is lost.

Test Plan:
1. Reset low for 10 ns, release, start=1 for 1 cycle, en=1, auto_reload=1 -> Q: 7,6,5,4,3,2,1,0,7,6,...; tc=1 in each cycle where Q shows 7 after a wrap (every 8 cycles); busy=1 throughout.
2. load=1 with load_val=3 in IDLE, then start, en=1, auto_reload=0 -> Q: 3,2,1,0 then held 0; tc high 1 cycle after the 0 edge; done=1, busy=0; a further start reruns 3,2,1,0.
3. In RUN at Q=5 (rld=7), drive en=0 for 4 cycles -> Q holds 5 and tc=0; on re-enable Q continues 4,3,...
4. In RUN at Q=0, assert load with load_val=2 on that same edge -> Q=2, no tc pulse, stays in RUN; next count sequence is 2,1,0 then wraps to 2.
5. load_val=0, auto_reload=1, start, en=1 -> Q=0 constant, tc=1 every cycle.
6. Assert reset (low) asynchronously mid-cycle while Q=4 -> Q=0, tc=busy=done=0 immediately without a clock edge; after release, start counts from 7 (rld reset to all ones).
